rx_pkt_payload_q_burst_dequeue: RTL

Parametrised burst dequeue engine for the per-flow RX payload queues. It sits between the RX consumer and the shared head/tail pointer memories and payload buffer. Per request, it reads up to `MAX_BURST` entries from one flow's circular queue and streams them out with a last flag. It then retires all of them with a single head-pointer write, instead of one entry per request.

---
 rtl/rx_pkt_payload_q_burst_dequeue.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/rx_pkt_payload_q_burst_dequeue.sv
// Burst dequeue engine: reads up to MAX_BURST entries of one flow queue and retires them with one head write.
// Latency: 3 cycles from request handshake to first beat with zero-wait memories, then one beat per cycle.
// Backpressure: any low rdy holds the FSM; at most 2 buffer reads are outstanding while resp_rdy stalls.
module rx_pkt_payload_q_burst_dequeue #(
    parameter int FLOW_ID_W = 4,
    parameter int Q_DEPTH_W = 4,
    parameter int ENTRY_W   = 64,
    parameter int BURST_W   = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_val,
    output logic                           req_rdy,
    input  logic [FLOW_ID_W-1:0]           req_flowid,
    input  logic [BURST_W-1:0]             req_max,
    output logic                           resp_val,
    input  logic                           resp_rdy,
    output logic [ENTRY_W-1:0]             resp_entry,
    output logic                           resp_is_empty,
    output logic                           resp_last,
    output logic [BURST_W-1:0]             resp_idx,
    output logic                           head_rd_req_val,
    input  logic                           head_rd_req_rdy,
    output logic [FLOW_ID_W-1:0]           head_rd_req_addr,
    input  logic                           head_rd_resp_val,
    output logic                           head_rd_resp_rdy,
    input  logic [Q_DEPTH_W:0]             head_rd_resp_data,
    output logic                           tail_rd_req_val,
    input  logic                           tail_rd_req_rdy,
    output logic [FLOW_ID_W-1:0]           tail_rd_req_addr,
    input  logic                           tail_rd_resp_val,
    output logic                           tail_rd_resp_rdy,
    input  logic [Q_DEPTH_W:0]             tail_rd_resp_data,
    output logic                           head_wr_req_val,
    input  logic                           head_wr_req_rdy,
    output logic [FLOW_ID_W-1:0]           head_wr_req_addr,
    output logic [Q_DEPTH_W:0]             head_wr_req_data,
    output logic                           buf_rd_req_val,
    input  logic                           buf_rd_req_rdy,
    output logic [FLOW_ID_W+Q_DEPTH_W-1:0] buf_rd_req_addr,
    input  logic                           buf_rd_resp_val,
    output logic                           buf_rd_resp_rdy,
    input  logic [ENTRY_W-1:0]             buf_rd_resp_data
);

    localparam int PW = Q_DEPTH_W + 1;
    localparam int CW = (PW > BURST_W) ? PW : BURST_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PTR_REQ,
        S_PTR_RESP,
        S_EMPTY,
        S_READ,
        S_WB
    } state_t;

    state_t state, state_nxt;

    logic [FLOW_ID_W-1:0] flowid_q;
    logic [BURST_W-1:0]   max_q;
    logic [PW-1:0]        head_q;
    logic [BURST_W-1:0]   n_q;
    logic [BURST_W-1:0]   ic_q;
    logic [BURST_W-1:0]   rc_q;

    logic [BURST_W-1:0]   max_in;
    logic [PW-1:0]        occ;
    logic [CW-1:0]        occ_w;
    logic [CW-1:0]        max_w;
    logic [BURST_W-1:0]   n_calc;
    logic [BURST_W-1:0]   outstanding;
    logic                 has_outstanding;
    logic                 can_issue;
    logic                 rc_last;
    logic [PW-1:0]        rd_ptr;
    logic                 ptr_both_vld;
    logic                 iss_hs;
    logic                 beat_hs;

    // A zero-length request still pulls one entry.
    assign max_in          = (req_max == '0) ? BURST_W'(1) : req_max;
    // Full-wrap subtraction: differing wrap bits with equal low bits yields 2^Q_DEPTH_W.
    assign occ             = tail_rd_resp_data - head_rd_resp_data;
    assign ptr_both_vld    = head_rd_resp_val && tail_rd_resp_val;
    assign outstanding     = ic_q - rc_q;
    assign has_outstanding = (outstanding != '0);
    assign can_issue       = (ic_q < n_q) && ({1'b0, outstanding} < (BURST_W + 1)'(2));
    assign rc_last         = (rc_q == (n_q - BURST_W'(1)));
    assign rd_ptr          = head_q + PW'(ic_q);
    assign iss_hs          = buf_rd_req_val && buf_rd_req_rdy;
    assign beat_hs         = (state == S_READ) && resp_val && resp_rdy;

    // Burst length is the smaller of queue occupancy and the requested maximum.
    always_comb begin
        occ_w  = CW'(occ);
        max_w  = CW'(max_q);
        n_calc = (occ_w < max_w) ? BURST_W'(occ_w) : max_q;
    end

    // Next-state and all handshake/data outputs; everything idles at zero outside its own state.
    always_comb begin
        state_nxt        = state;
        req_rdy          = 1'b0;
        resp_val         = 1'b0;
        resp_entry       = '0;
        resp_is_empty    = 1'b0;
        resp_last        = 1'b0;
        resp_idx         = '0;
        head_rd_req_val  = 1'b0;
        head_rd_req_addr = '0;
        head_rd_resp_rdy = 1'b0;
        tail_rd_req_val  = 1'b0;
        tail_rd_req_addr = '0;
        tail_rd_resp_rdy = 1'b0;
        head_wr_req_val  = 1'b0;
        head_wr_req_addr = '0;
        head_wr_req_data = '0;
        buf_rd_req_val   = 1'b0;
        buf_rd_req_addr  = '0;
        buf_rd_resp_rdy  = 1'b0;
        case (state)
            S_IDLE: begin
                req_rdy = 1'b1;
                if (req_val) state_nxt = S_PTR_REQ;
            end
            S_PTR_REQ: begin
                head_rd_req_val  = 1'b1;
                tail_rd_req_val  = 1'b1;
                head_rd_req_addr = flowid_q;
                tail_rd_req_addr = flowid_q;
                if (head_rd_req_rdy && tail_rd_req_rdy) state_nxt = S_PTR_RESP;
            end
            S_PTR_RESP: begin
                head_rd_resp_rdy = ptr_both_vld;
                tail_rd_resp_rdy = ptr_both_vld;
                if (ptr_both_vld) state_nxt = (occ == '0) ? S_EMPTY : S_READ;
            end
            S_EMPTY: begin
                resp_val      = 1'b1;
                resp_is_empty = 1'b1;
                resp_last     = 1'b1;
                if (resp_rdy) state_nxt = S_IDLE;
            end
            S_READ: begin
                buf_rd_req_val  = can_issue;
                buf_rd_req_addr = {flowid_q, rd_ptr[Q_DEPTH_W-1:0]};
                resp_val        = buf_rd_resp_val && has_outstanding;
                buf_rd_resp_rdy = resp_rdy && has_outstanding;
                resp_entry      = buf_rd_resp_data;
                resp_idx        = rc_q;
                resp_last       = rc_last;
                if (resp_val && resp_rdy && rc_last) state_nxt = S_WB;
            end
            S_WB: begin
                head_wr_req_val  = 1'b1;
                head_wr_req_addr = flowid_q;
                head_wr_req_data = head_q + PW'(n_q);
                if (head_wr_req_rdy) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Request capture, pointer capture and issue/return counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flowid_q <= '0;
            max_q    <= '0;
            head_q   <= '0;
            n_q      <= '0;
            ic_q     <= '0;
            rc_q     <= '0;
        end else begin
            if (state == S_IDLE && req_val) begin
                flowid_q <= req_flowid;
                max_q    <= max_in;
                ic_q     <= '0;
                rc_q     <= '0;
            end
            if (state == S_PTR_RESP && ptr_both_vld) begin
                head_q <= head_rd_resp_data;
                n_q    <= n_calc;
            end
            if (iss_hs)  ic_q <= ic_q + BURST_W'(1);
            if (beat_hs) rc_q <= rc_q + BURST_W'(1);
        end
    end

endmodule
